ex_mdu: RTL and testbench

Parametrised multi-cycle RV32M multiply/divide unit sitting beside the combinational execute stage. It accepts one M-extension operation at a time (func7 = 0000001 on the R-type opcode), runs an iterative shift-add multiplier or restoring divider, and drives `hold_flag_o` to the pipeline controller so fetch/decode stall until the result is written back. Results return through the normal register-write path (`rd_addr_o`, `rd_data_o`, `reg_wen_o`), muxed into the execute stage outputs by the integrating logic.

---
 rtl/ex_mdu_if.sv | 30 +++
 rtl/ex_mdu.sv | 175 +++++++++++++++++
 tb/tb_ex_mdu.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// Issue/writeback bundle between the pipeline controller and the iterative RV32M unit.
// The master side issues operations and the slave side returns the result.
interface ex_mdu_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            kill_i;
  logic            busy_o;
  logic            hold_flag_o;
  logic            done_o;
  logic [XLEN-1:0] rd_data_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;

  modport master (
    output start_i, func3_i, op1_i, op2_i, rd_addr_i, kill_i,
    input  busy_o, hold_flag_o, done_o, rd_data_o, rd_addr_o, reg_wen_o
  );

  modport slave (
    input  start_i, func3_i, op1_i, op2_i, rd_addr_i, kill_i,
    output busy_o, hold_flag_o, done_o, rd_data_o, rd_addr_o, reg_wen_o
  );

endinterface

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M unit: shift-add multiplier and restoring divider on magnitudes,
// with sign fix-up on the final iteration and a one-cycle path for divide corner cases.
module ex_mdu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input logic     clk,
  input logic     rst_n,
  ex_mdu_if.slave mdu
);

  localparam logic [XLEN-1:0]  MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand shifted left each step; its low half holds the divisor in divide mode.
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        func3_q, func3_d;
  logic [4:0]        op_rd_q, op_rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic [4:0]        rd_addr_q, rd_addr_d;

  logic            accept, is_div, sgn1, sgn2, div_zero, div_ovf;
  logic [XLEN-1:0] abs1, abs2, special_res;

  logic [2*XLEN-1:0] mul_sum, mul_prod, div_step;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff, mul_res, div_sel, div_res;
  logic              rem_ge;

  // Issue-time decode and operand preparation
  always_comb begin
    accept = (state_q == StIdle) & mdu.start_i & ~mdu.kill_i;
    is_div = mdu.func3_i[2];
    sgn1   = (is_div ? ~mdu.func3_i[0] : (mdu.func3_i[1:0] != 2'b11)) & mdu.op1_i[XLEN-1];
    sgn2   = (is_div ? ~mdu.func3_i[0] : ~mdu.func3_i[1]) & mdu.op2_i[XLEN-1];
    abs1   = sgn1 ? -mdu.op1_i : mdu.op1_i;
    abs2   = sgn2 ? -mdu.op2_i : mdu.op2_i;
    div_zero = is_div & (mdu.op2_i == '0);
    div_ovf  = is_div & ~mdu.func3_i[0] & (mdu.op1_i == MinNeg) & (mdu.op2_i == '1);
    if (div_zero) begin
      special_res = mdu.func3_i[1] ? mdu.op1_i : '1;
    end else begin
      special_res = mdu.func3_i[1] ? '0 : mdu.op1_i;
    end
  end

  // One iteration of each algorithm plus the final sign fix-up
  always_comb begin
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_prod = neg_q ? -mul_sum : mul_sum;
    mul_res  = (func3_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // acc holds {remainder, dividend}; shifting pulls the next dividend bit into the remainder
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_ge   = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
    rem_diff = rem_sh[XLEN-1:0] - mcand_q[XLEN-1:0];
    if (rem_ge) begin
      div_step = {rem_diff, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step = {acc_q[2*XLEN-2:0], 1'b0};
    end
    div_sel = func3_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
    div_res = neg_q ? -div_sel : div_sel;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    op_rd_d   = op_rd_q;
    neg_d     = neg_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          func3_d = mdu.func3_i[1:0];
          op_rd_d = mdu.rd_addr_i;
          neg_d   = (is_div & mdu.func3_i[1]) ? sgn1 : (sgn1 ^ sgn2);
          cnt_d   = CntInit;
          if (div_zero | div_ovf) begin
            rd_data_d = special_res;
            rd_addr_d = mdu.rd_addr_i;
            state_d   = StDone;
          end else if (is_div) begin
            acc_d   = {{XLEN{1'b0}}, abs1};
            mcand_d = {{XLEN{1'b0}}, abs2};
            state_d = StDiv;
          end else begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, abs1};
            mplier_d = abs2;
            state_d  = StMul;
          end
        end
      end
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          rd_data_d = mul_res;
          rd_addr_d = op_rd_q;
          state_d   = StDone;
        end
      end
      StDiv: begin
        acc_d = div_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          rd_data_d = div_res;
          rd_addr_d = op_rd_q;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flush abandons the op and leaves the last published result untouched
    if (mdu.kill_i) begin
      state_d   = StIdle;
      rd_data_d = rd_data_q;
      rd_addr_d = rd_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      func3_q   <= '0;
      op_rd_q   <= '0;
      neg_q     <= 1'b0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      op_rd_q   <= op_rd_d;
      neg_q     <= neg_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    mdu.busy_o      = state_q != StIdle;
    mdu.hold_flag_o = accept | (state_q == StMul) | (state_q == StDiv);
    mdu.done_o      = (state_q == StDone) & ~mdu.kill_i;
    mdu.rd_data_o   = rd_data_q;
    mdu.rd_addr_o   = rd_addr_q;
    mdu.reg_wen_o   = mdu.done_o & (rd_addr_q != 5'd0);
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scenario-driven bench for ex_mdu; expected results queue up at issue and are
// retired when done_o is seen.
module tb_ex_mdu;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mdu_if #(.XLEN(XLEN)) bus ();

  ex_mdu #(.XLEN(XLEN), .CNT_W($clog2(XLEN) + 1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mdu  (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_data[$];
  logic [4:0]  sb_addr[$];

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, su;
    logic [63:0] p;
    logic signed [31:0] qa, qb;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    su = {32'b0, b};
    qa = a;
    qb = b;
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * su; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = qa / qb;
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = qa % qb;
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op, queue its expectation, and wait (bounded) for done_o.
  // lat is the cycle offset of done_o from the issue cycle, -1 on timeout.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, output int lat,
                       output int hold_cnt, output logic [31:0] data, output logic [4:0] addr,
                       output logic wen);
    lat = -1;
    hold_cnt = 0;
    data = 'x;
    addr = 'x;
    wen = 1'bx;
    @(posedge clk);
    #1;
    bus.start_i   = 1'b1;
    bus.func3_i   = f3;
    bus.op1_i     = a;
    bus.op2_i     = b;
    bus.rd_addr_i = rd;
    sb_data.push_back(exp);
    sb_addr.push_back(rd);
    @(negedge clk);
    if (bus.hold_flag_o) hold_cnt++;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.hold_flag_o) hold_cnt++;
      if (bus.done_o) begin
        lat  = n;
        data = bus.rd_data_o;
        addr = bus.rd_addr_o;
        wen  = bus.reg_wen_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.busy_o, bus.hold_flag_o, bus.done_o, bus.reg_wen_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags_in_reset got=%b exp=0000",
               {bus.busy_o, bus.hold_flag_o, bus.done_o, bus.reg_wen_o});
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.hold_flag_o, bus.done_o, bus.reg_wen_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.busy_o, bus.hold_flag_o, bus.done_o, bus.reg_wen_o});
    end
    checks++;
    if (bus.rd_data_o !== 32'd0 || bus.rd_addr_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h addr=%0d exp data=0 addr=0",
               bus.rd_data_o, bus.rd_addr_o);
    end
  endtask

  task automatic test_mul();
    vec_t tbl[5];
    int lat, hc;
    logic [31:0] d, ed;
    logic [4:0] ad, ea;
    logic w;
    tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001};
    tbl[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE};
    tbl[2] = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000};
    tbl[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000};
    tbl[4] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 5'd5, 32'hFFFF_FFFF};
    foreach (tbl[i]) begin
      do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, lat, hc, d, ad, w);
      ed = sb_data.pop_front();
      ea = sb_addr.pop_front();
      checks++;
      if (lat != 33) begin
        failures++;
        $display("FAIL mul_latency[%0d] got=%0d exp=33", i, lat);
      end
      checks++;
      if (hc != 33) begin
        failures++;
        $display("FAIL mul_hold_cycles[%0d] got=%0d exp=33", i, hc);
      end
      checks++;
      if (d !== ed) begin
        failures++;
        $display("FAIL mul_data[%0d] got=%h exp=%h", i, d, ed);
      end
      checks++;
      if ({w, ad} !== {1'b1, ea}) begin
        failures++;
        $display("FAIL mul_wb[%0d] got wen=%b addr=%0d exp wen=1 addr=%0d", i, w, ad, ea);
      end
    end
  endtask

  task automatic test_div();
    vec_t tbl[4];
    int lat, hc;
    logic [31:0] d, ed;
    logic [4:0] ad, ea;
    logic w;
    tbl[0] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFD};
    tbl[1] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF};
    tbl[2] = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8, 32'h7FFF_FFFC};
    tbl[3] = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 32'h0000_0001};
    foreach (tbl[i]) begin
      do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, lat, hc, d, ad, w);
      ed = sb_data.pop_front();
      ea = sb_addr.pop_front();
      checks++;
      if (lat != 33) begin
        failures++;
        $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat);
      end
      checks++;
      if (d !== ed || ad !== ea) begin
        failures++;
        $display("FAIL div_data[%0d] got=%h/%0d exp=%h/%0d", i, d, ad, ed, ea);
      end
      // Strobe is one cycle wide and the result stays put afterwards
      @(negedge clk);
      checks++;
      if (bus.done_o !== 1'b0 || bus.reg_wen_o !== 1'b0 || bus.rd_data_o !== ed) begin
        failures++;
        $display("FAIL div_after_done got done=%b wen=%b data=%h exp done=0 wen=0 data=%h",
                 bus.done_o, bus.reg_wen_o, bus.rd_data_o, ed);
      end
    end
  endtask

  task automatic test_special();
    vec_t tbl[6];
    int lat, hc;
    logic [31:0] d, ed;
    logic [4:0] ad, ea;
    logic w;
    tbl[0] = '{3'd4, 32'h0000_0005, 32'h0000_0000, 5'd10, 32'hFFFF_FFFF};
    tbl[1] = '{3'd6, 32'h0000_0005, 32'h0000_0000, 5'd11, 32'h0000_0005};
    tbl[2] = '{3'd5, 32'h0000_0005, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF};
    tbl[3] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 5'd13, 32'h0000_0005};
    tbl[4] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000};
    tbl[5] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000};
    foreach (tbl[i]) begin
      do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, lat, hc, d, ad, w);
      ed = sb_data.pop_front();
      ea = sb_addr.pop_front();
      checks++;
      if (lat != 1 || hc != 1) begin
        failures++;
        $display("FAIL special_timing[%0d] got lat=%0d hold=%0d exp lat=1 hold=1", i, lat, hc);
      end
      checks++;
      if (d !== ed || {w, ad} !== {1'b1, ea}) begin
        failures++;
        $display("FAIL special_data[%0d] got=%h wen=%b addr=%0d exp=%h wen=1 addr=%0d",
                 i, d, w, ad, ed, ea);
      end
    end
  endtask

  task automatic test_kill();
    int seen;
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.func3_i = 3'd0;
    bus.op1_i = 32'd1234;
    bus.op2_i = 32'd5678;
    bus.rd_addr_i = 5'd20;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.kill_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL kill_done_in_kill_cycle got=%b exp=0", bus.done_o);
    end
    @(posedge clk);
    #1 bus.kill_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.hold_flag_o !== 1'b0) begin
      failures++;
      $display("FAIL kill_idle got busy=%b hold=%b exp busy=0 hold=0",
               bus.busy_o, bus.hold_flag_o);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o || bus.reg_wen_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL kill_no_writeback got=%0d strobes exp=0", seen);
    end
  endtask

  task automatic test_start_kill();
    int seen;
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.kill_i = 1'b1;
    bus.func3_i = 3'd4;
    bus.op1_i = 32'd9;
    bus.op2_i = 32'd0;
    bus.rd_addr_i = 5'd21;
    @(negedge clk);
    checks++;
    if (bus.hold_flag_o !== 1'b0) begin
      failures++;
      $display("FAIL start_kill_hold got=%b exp=0", bus.hold_flag_o);
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.kill_i = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy_o || bus.done_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL start_kill_accepted got=%0d active cycles exp=0", seen);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.func3_i = 3'd5;
    bus.op1_i = 32'd1000;
    bus.op2_i = 32'd7;
    bus.rd_addr_i = 5'd22;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy_o, bus.hold_flag_o, bus.done_o, bus.reg_wen_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_flags got=%b exp=0000",
               {bus.busy_o, bus.hold_flag_o, bus.done_o, bus.reg_wen_o});
    end
    checks++;
    if (bus.rd_data_o !== 32'd0 || bus.rd_addr_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got data=%h addr=%0d exp data=0 addr=0",
               bus.rd_data_o, bus.rd_addr_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_x0();
    int lat, hc;
    logic [31:0] d, ed;
    logic [4:0] ad, ea;
    logic w;
    do_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, lat, hc, d, ad, w);
    ed = sb_data.pop_front();
    ea = sb_addr.pop_front();
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL x0_done got lat=%0d exp=33", lat);
    end
    checks++;
    if (d !== ed || ad !== ea || w !== 1'b0) begin
      failures++;
      $display("FAIL x0_wb got data=%h addr=%0d wen=%b exp data=%h addr=%0d wen=0",
               d, ad, w, ed, ea);
    end
  endtask

  // Each do_op issues on the edge right after the previous done_o, i.e. at T+34
  task automatic test_back_to_back();
    int lat, hc;
    logic [31:0] d, ed;
    logic [4:0] ad, ea;
    logic w;
    for (int i = 0; i < 3; i++) begin
      do_op(3'd1, 32'h1234_5678 + 32'(i), 32'hFEDC_BA98, 5'(i + 24),
            ref_op(3'd1, 32'h1234_5678 + 32'(i), 32'hFEDC_BA98), lat, hc, d, ad, w);
      ed = sb_data.pop_front();
      ea = sb_addr.pop_front();
      checks++;
      if (lat != 33 || hc != 33) begin
        failures++;
        $display("FAIL b2b_timing[%0d] got lat=%0d hold=%0d exp 33/33", i, lat, hc);
      end
      checks++;
      if (d !== ed || ad !== ea) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%h/%0d exp=%h/%0d", i, d, ad, ed, ea);
      end
    end
  endtask

  task automatic test_random();
    int lat, hc, exp_lat;
    logic [31:0] d, ed, a, b;
    logic [31:0] corner[5];
    logic [4:0] ad, ea, rd;
    logic [2:0] f3;
    logic w;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rd = 5'($urandom_range(0, 31));
      exp_lat = (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                ? 1 : 33;
      do_op(f3, a, b, rd, ref_op(f3, a, b), lat, hc, d, ad, w);
      ed = sb_data.pop_front();
      ea = sb_addr.pop_front();
      checks++;
      if (lat != exp_lat || d !== ed || ad !== ea || w !== (ea != 5'd0)) begin
        failures++;
        $display("FAIL rand[%0d] f3=%0d a=%h b=%h got lat=%0d data=%h addr=%0d wen=%b exp lat=%0d data=%h addr=%0d",
                 i, f3, a, b, lat, d, ad, w, exp_lat, ed, ea);
      end
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.func3_i = 3'd0;
    bus.op1_i = '0;
    bus.op2_i = '0;
    bus.rd_addr_i = 5'd0;
    bus.kill_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_kill();
    test_start_kill();
    test_reset_mid();
    test_x0();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
